// File: rtl/sram_bus_bridge.sv
// Native valid/ready memory bus to NUM_BANKS 1024x32 single-port SRAM macros.
// Zero-fills every bank after reset when INIT_ZERO=1, since the macros power up undefined.
module sram_bus_bridge #(
    parameter int NUM_BANKS = 4,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_valid_i,
    output logic                      mem_ready_o,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               mem_wdata_i,
    input  logic [3:0]                mem_wstrb_i,
    output logic [31:0]               mem_rdata_o,
    output logic                      init_done_o,
    output logic [NUM_BANKS-1:0]      sram_cs_o,
    output logic [9:0]                sram_addr_o,
    output logic [31:0]               sram_data_o,
    output logic [3:0]                sram_mask_o,
    output logic                      sram_wren_o,
    input  logic [NUM_BANKS*32-1:0]   sram_data_i
);

    // Bank index needs at least one bit to be a legal vector; it is forced to 0 with one bank.
    localparam int BWV = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [BWV-1:0]    bank_q, bank_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic [BWV-1:0]    req_bank_s;

    logic [NUM_BANKS-1:0] cs_s;
    logic [9:0]           addr_s;
    logic [31:0]          data_s;
    logic [3:0]           mask_s;
    logic                 wren_s;

    // Address bits outside word and bank fields are deliberately ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^{mem_addr_i[31:12], mem_addr_i[1:0]};

    function automatic logic [BWV-1:0] bank_of(input logic [31:0] addr);
        if (NUM_BANKS > 1) begin
            bank_of = addr[12 +: BWV];
        end else begin
            bank_of = '0;
        end
    endfunction

    assign req_bank_s = bank_of(mem_addr_i);

    // Next-state, datapath capture and SRAM request decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        cs_s    = '0;
        addr_s  = 10'd0;
        data_s  = 32'd0;
        mask_s  = 4'h0;
        wren_s  = 1'b0;
        case (state_q)
            ST_INIT: begin
                cs_s   = '1;
                wren_s = 1'b1;
                mask_s = 4'hF;
                addr_s = cnt_q;
                cnt_d  = cnt_q + 10'd1;
                if (cnt_q == 10'd1023) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (mem_valid_i) begin
                    cs_s[req_bank_s] = 1'b1;
                    addr_s = mem_addr_i[11:2];
                    data_s = mem_wdata_i;
                    mask_s = mem_wstrb_i;
                    wren_s = |mem_wstrb_i;
                    bank_d = req_bank_s;
                    state_d = (|mem_wstrb_i) ? ST_ACK : ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // Mux by the bank latched at issue; the live address may already have moved.
                rdata_d = sram_data_i[32*bank_q +: 32];
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT_ZERO ? ST_INIT : ST_IDLE;
            cnt_q   <= 10'd0;
            bank_q  <= '0;
            rdata_q <= 32'd0;
            done_q  <= ~INIT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Hold the macros idle while reset is applied so no write can slip through.
    assign sram_cs_o   = rst_i ? '0     : cs_s;
    assign sram_addr_o = rst_i ? 10'd0  : addr_s;
    assign sram_data_o = rst_i ? 32'd0  : data_s;
    assign sram_mask_o = rst_i ? 4'h0   : mask_s;
    assign sram_wren_o = rst_i ? 1'b0   : wren_s;

    assign mem_ready_o = (state_q == ST_ACK);
    assign mem_rdata_o = rdata_q;
    assign init_done_o = done_q;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Scoreboard bench for sram_bus_bridge: driver pushes expected responses, monitor pops on ready.
module tb_sram_bus_bridge;

    logic         clk;
    logic         rst_i;
    logic         mem_valid_i;
    logic         mem_ready_o;
    logic [31:0]  mem_addr_i;
    logic [31:0]  mem_wdata_i;
    logic [3:0]   mem_wstrb_i;
    logic [31:0]  mem_rdata_o;
    logic         init_done_o;
    logic [3:0]   sram_cs_o;
    logic [9:0]   sram_addr_o;
    logic [31:0]  sram_data_o;
    logic [3:0]   sram_mask_o;
    logic         sram_wren_o;
    logic [127:0] sram_rd_s;

    sram_bus_bridge #(.NUM_BANKS(4), .INIT_ZERO(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_rdata_o(mem_rdata_o), .init_done_o(init_done_o),
        .sram_cs_o(sram_cs_o), .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
        .sram_mask_o(sram_mask_o), .sram_wren_o(sram_wren_o), .sram_data_i(sram_rd_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro models: 1-cycle read latency, byte write mask; random power-up contents.
    logic [31:0] smem [4][1024];
    logic [31:0] sdout [4];
    bit          filled_r = 1'b0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (!filled_r) begin
            for (int b = 0; b < 4; b++)
                for (int w = 0; w < 1024; w++)
                    smem[b][w] <= $urandom;
            filled_r <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sram_cs_o[b]) begin
                    if (sram_wren_o) begin
                        for (int i = 0; i < 4; i++)
                            if (sram_mask_o[i]) smem[b][sram_addr_o][8*i +: 8] <= sram_data_o[8*i +: 8];
                    end else begin
                        sdout[b] <= smem[b][sram_addr_o];
                    end
                end
            end
            if ((|sram_cs_o) && sram_wren_o && init_done_o) wr_cnt <= wr_cnt + 1;
        end
    end
    assign sram_rd_s = {sdout[3], sdout[2], sdout[1], sdout[0]};

    // Reference model: flat 16 KiB word array, addressed by bank*1024+word.
    logic [31:0] ref_mem [4096];
    logic [31:0] last_rd = 32'd0;
    int          exp_wr = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
        int          issue;
        int          lat;
    } item_t;
    item_t sbq[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return ((a >> 12) % 4) * 1024 + ((a >> 2) % 1024);
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;
        last_rd = 32'd0;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst_i && mem_ready_o) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                item_t it;
                it = sbq.pop_front();
                if (it.lat >= 0) chk(it.is_rd ? "rd_latency" : "wr_latency", cyc - it.issue, it.lat);
                chk(it.is_rd ? "rdata" : "rdata_hold_on_wr", mem_rdata_o, it.rdata);
            end
        end
    end

    task automatic wait_ready(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issues one request, holds it through ACK, and records the expected outcome.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        item_t it;
        int idx;
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i  = a;
        mem_wdata_i = d;
        mem_wstrb_i = s;
        idx = ref_idx(a);
        it.is_rd = (s == 4'h0);
        it.issue = cyc;
        it.lat   = (s == 4'h0) ? 2 : 1;
        if (s == 4'h0) begin
            last_rd = ref_mem[idx];
        end else begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
            exp_wr++;
        end
        it.rdata = last_rd;
        sbq.push_back(it);
        #1;
        chk("cs_onehot", {28'd0, sram_cs_o}, 32'd1 << ((a >> 12) % 4));
        chk("wren", {31'd0, sram_wren_o}, {31'd0, (s != 4'h0)});
        wait_ready(20);
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("init_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        item_t       it;
        rst_i = 1'b1;
        mem_valid_i = 1'b0;
        mem_addr_i = 32'd0;
        mem_wdata_i = 32'd0;
        mem_wstrb_i = 4'h0;
        ref_clear();
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, mem_ready_o}, 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        chk("rst_done", {31'd0, init_done_o}, 32'd0);
        chk("rst_cs", {28'd0, sram_cs_o}, 32'd0);
        chk("rst_wren", {31'd0, sram_wren_o}, 32'd0);

        // Release reset with a read already pending; it must wait for the zero-fill.
        rst_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_addr_i = 32'h0000_2008;
        it.is_rd = 1'b1; it.rdata = 32'd0; it.issue = cyc; it.lat = -1;
        sbq.push_back(it);
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k == 1023) chk("done_low_at_1023", {31'd0, init_done_o}, 32'd0);
            if (k == 1024) chk("done_high_at_1024", {31'd0, init_done_o}, 32'd1);
            if (mem_ready_o && !init_done_o) chk("ready_during_init", 32'd1, 32'd0);
        end
        wait_ready(10);

        for (int b = 0; b < 4; b++) do_req((b << 12) | (b * 12 + 4), 32'd0, 4'h0);

        do_req(32'h0000_1004, 32'hDEADBEEF, 4'hF);
        do_req(32'h0000_1004, 32'd0, 4'h0);

        do_req(32'h0000_2008, 32'h11223344, 4'hF);
        do_req(32'h0000_2008, 32'hAABBCCDD, 4'b0101);
        do_req(32'h0000_2008, 32'd0, 4'h0);
        chk("strobe_merge_ref", ref_mem[ref_idx(32'h0000_2008)], 32'h11BB33DD);

        for (int b = 0; b < 4; b++) do_req((b << 12) | (5 << 2), 32'hA000_0000 + b * 32'h1111, 4'hF);
        for (int b = 0; b < 4; b++) do_req((b << 12) | (5 << 2), 32'd0, 4'h0);
        for (int b = 0; b < 4; b++) do_req(32'h0010_4000 | (b << 12) | (5 << 2), 32'd0, 4'h0);

        do_req(32'h0000_3010, 32'd0, 4'h0);
        do_req(32'h0000_3010, 32'h5A5A_0F0F, 4'hF);
        do_req(32'h0000_3010, 32'd0, 4'h0);
        @(negedge clk);
        mem_valid_i = 1'b0;
        @(negedge clk);
        chk("write_count_directed", wr_cnt, exp_wr);

        for (int n = 0; n < 60; n++) begin
            a = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'd0,
                 2'($urandom_range(0, 3)), 7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            do_req(a, $urandom, s);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                mem_valid_i = 1'b0;
            end
        end
        @(negedge clk);
        mem_valid_i = 1'b0;
        @(negedge clk);
        chk("write_count_random", wr_cnt, exp_wr);

        // Reset while a read sits in RD: no ready pulse, rdata cleared, fill restarts.
        do_req(32'h0000_1004, 32'd0, 4'h0);
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_addr_i = 32'h0000_2008;
        mem_wstrb_i = 4'h0;
        @(negedge clk);
        rst_i = 1'b1;
        mem_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_rdata", mem_rdata_o, 32'd0);
        chk("rst_rd_ready", {31'd0, mem_ready_o}, 32'd0);
        chk("rst_rd_done", {31'd0, init_done_o}, 32'd0);
        rst_i = 1'b0;
        ref_clear();
        wait_done(1100);
        do_req(32'h0000_1004, 32'd0, 4'h0);
        do_req(32'h0000_2008, 32'd0, 4'h0);
        @(negedge clk);
        mem_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
